// File: rtl/serial_negate_if.sv
// Valid/ready bundle for the serial negate unit.
// master drives operands and accepts results; slave is the unit.
interface serial_negate_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, ovf, zero
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, ovf, zero
  );
endinterface

// File: rtl/serial_negate.sv
// Serial pass/negate/abs/-abs unit, DIGIT bits per clock.
// One operand in flight; result held until out_ready.
module serial_negate #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst,
  serial_negate_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             neg;
  logic             ovf_nx;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_in;
  logic             is_min;
  logic             last;
  logic [DIGIT-1:0] d;
  logic [DIGIT-1:0] r;
  logic [DIGIT:0]   sum;

  assign is_min = bus.in_data == {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    neg_in = 1'b0;
    unique case (bus.mode)
      2'b00: neg_in = 1'b0;
      2'b01: neg_in = 1'b1;
      2'b10: neg_in = bus.in_data[WIDTH-1];
      2'b11: neg_in = ~bus.in_data[WIDTH-1];
    endcase
  end

  // Negation is ~x + 1, rippled one digit per cycle from the LSB.
  assign d   = sh[DIGIT-1:0];
  assign sum = {1'b0, ~d} + {{DIGIT{1'b0}}, carry};
  assign r   = neg ? sum[DIGIT-1:0] : d;

  if (N == 1) begin : g_one
    assign shifted = r;
  end else begin : g_many
    assign shifted = {r, sh[WIDTH-1:DIGIT]};
  end

  assign last = cnt == CW'(N - 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_n = RUN;
      RUN:     if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= '0;
      res_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b1;
      neg    <= 1'b0;
      ovf_nx <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh     <= bus.in_data;
            carry  <= 1'b1;
            cnt    <= '0;
            neg    <= neg_in;
            ovf_nx <= neg_in & is_min;
          end
        end
        RUN: begin
          sh  <= shifted;
          cnt <= cnt + 1'b1;
          if (neg) carry <= sum[DIGIT];
          if (last) begin
            res_q  <= shifted;
            ovf_q  <= ovf_nx;
            zero_q <= shifted == '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = state == DONE;
  assign bus.out_data  = res_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_negate.sv
// Bench for serial_negate: 8x1 and 16x4 instances against
// an arithmetic reference plus directed literal vectors.
module tb_serial_negate;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_negate_if #(.WIDTH(8))  a ();
  serial_negate_if #(.WIDTH(16)) b ();

  serial_negate #(.WIDTH(8), .DIGIT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave)
  );
  serial_negate #(.WIDTH(16), .DIGIT(4)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave)
  );

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // {zero, ovf, data} from signed integer arithmetic
  function automatic logic [17:0] ref_op(input int w,
      input logic [15:0] x, input logic [1:0] m);
    longint half, sx, t;
    logic [63:0] tt;
    logic [15:0] res;
    logic o;
    half = longint'(1) << (w - 1);
    sx = longint'(x) & (2 * half - 1);
    if (sx >= half) sx = sx - 2 * half;
    case (m)
      2'd0:    t = sx;
      2'd1:    t = -sx;
      2'd2:    t = (sx < 0) ? -sx : sx;
      default: t = (sx < 0) ? sx : -sx;
    endcase
    o = t >= half;
    tt = 64'(t & (2 * half - 1));
    res = tt[15:0];
    return {res == 16'd0, o, res};
  endfunction

  typedef struct {
    int          ph;
    int          rem;
    logic [17:0] e;
    logic [17:0] h;
  } mst_t;

  // ph: 0 idle, 1 busy, 2 result offered
  function automatic mst_t mstep(input mst_t s, input int w,
      input int n, input logic r, input logic iv, input logic ordy,
      input logic [15:0] dd, input logic [1:0] m);
    mst_t q;
    q = s;
    if (r) begin
      q.ph = 0;
      q.h = '0;
    end else begin
      case (s.ph)
        0: if (iv) begin
          q.ph = 1;
          q.rem = n;
          q.e = ref_op(w, dd, m);
        end
        1: begin
          q.rem = s.rem - 1;
          if (q.rem == 0) begin
            q.ph = 2;
            q.h = s.e;
          end
        end
        default: if (ordy) q.ph = 0;
      endcase
    end
    return q;
  endfunction

  mst_t ma, mb;
  bit arm_a = 0, arm_b = 0;
  int acc_a = 0, em_a = 0;

  always @(negedge clk) begin
    if (arm_a)
      chk("cyc_a",
        {a.out_valid, a.in_ready, a.zero, a.ovf, 8'h00, a.out_data},
        {ma.ph == 2, ma.ph == 0 && !rst, ma.h});
    if (!rst && a.in_valid && a.in_ready) acc_a++;
    if (!rst && a.out_valid && a.out_ready) em_a++;
    ma = mstep(ma, 8, 8, rst, a.in_valid, a.out_ready,
               {8'h00, a.in_data}, a.mode);
    if (rst) arm_a = 1;
  end

  always @(negedge clk) begin
    if (arm_b)
      chk("cyc_b",
        {b.out_valid, b.in_ready, b.zero, b.ovf, b.out_data},
        {mb.ph == 2, mb.ph == 0 && !rst, mb.h});
    mb = mstep(mb, 16, 4, rst, b.in_valid, b.out_ready,
               b.in_data, b.mode);
    if (rst) arm_b = 1;
  end

  task automatic opa(input string nm, input logic [7:0] dd,
      input logic [1:0] m, input logic [7:0] ed, input logic eo,
      input logic ez, input int hold);
    int w, lat;
    @(posedge clk); #1;
    a.in_valid = 1'b1;
    a.in_data = dd;
    a.mode = m;
    w = 0;
    while (!a.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    a.in_data = ~dd;
    a.mode = ~m;
    lat = 0;
    while (!a.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd8);
    chk(nm, {a.out_data, a.ovf, a.zero}, {ed, eo, ez});
    for (int i = 0; i < hold; i++) begin
      a.in_valid = (i == 1);
      a.in_data = 8'h33;
      a.mode = 2'b01;
      @(posedge clk); #1;
      chk({nm, "_hold"}, {a.out_valid, a.in_ready, a.out_data},
          {1'b1, 1'b0, ed});
    end
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    @(posedge clk); #1;
    a.out_ready = 1'b0;
    chk({nm, "_rel"}, {a.out_valid, a.in_ready}, 2'b01);
  endtask

  task automatic opb(input string nm, input logic [15:0] dd,
      input logic [1:0] m, input logic [15:0] ed, input logic eo,
      input logic ez);
    int w, lat;
    @(posedge clk); #1;
    b.in_valid = 1'b1;
    b.in_data = dd;
    b.mode = m;
    w = 0;
    while (!b.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    b.in_data = ~dd;
    lat = 0;
    while (!b.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd4);
    chk(nm, {b.out_data, b.ovf, b.zero}, {ed, eo, ez});
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    b.out_ready = 1'b0;
    chk({nm, "_rel"}, {b.out_valid, b.in_ready}, 2'b01);
  endtask

  initial begin
    int acc0, em0, to, w;
    bit rnd_done;
    a.in_valid = 0; a.in_data = 0; a.mode = 0; a.out_ready = 0;
    b.in_valid = 0; b.in_data = 0; b.mode = 0; b.out_ready = 0;
    ma = '{0, 0, '0, '0};
    mb = '{0, 0, '0, '0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {a.out_valid, a.out_data, a.ovf, a.zero,
        b.out_valid, b.out_data}, '0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {a.in_ready, b.in_ready}, 2'b11);

    chk("pin_neg01", ref_op(8, 16'h0001, 2'd1), {2'b00, 16'h00FF});
    chk("pin_abs80", ref_op(8, 16'h0080, 2'd2), {2'b01, 16'h0080});
    chk("pin_nabsff", ref_op(8, 16'h00FF, 2'd3), {2'b00, 16'h00FF});
    chk("pin_w16", ref_op(16, 16'h1234, 2'd1), {2'b00, 16'hEDCC});

    opa("neg01", 8'h01, 2'b01, 8'hFF, 1'b0, 1'b0, 0);
    opa("neg00", 8'h00, 2'b01, 8'h00, 1'b0, 1'b1, 0);
    opa("neg7f", 8'h7F, 2'b01, 8'h81, 1'b0, 1'b0, 0);
    opa("neg80", 8'h80, 2'b01, 8'h80, 1'b1, 1'b0, 0);
    opa("pass20", 8'h20, 2'b00, 8'h20, 1'b0, 1'b0, 0);
    opa("absff", 8'hFF, 2'b10, 8'h01, 1'b0, 1'b0, 0);
    opa("abs80", 8'h80, 2'b10, 8'h80, 1'b1, 1'b0, 0);
    opa("nabs7f", 8'h7F, 2'b11, 8'h81, 1'b0, 1'b0, 0);
    opa("nabsff", 8'hFF, 2'b11, 8'hFF, 1'b0, 1'b0, 0);
    opa("bp_neg01", 8'h01, 2'b01, 8'hFF, 1'b0, 1'b0, 5);

    @(posedge clk); #1;
    a.in_valid = 1'b1;
    a.in_data = 8'h55;
    a.mode = 2'b01;
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid", {a.out_valid, a.out_data, a.ovf, a.zero}, '0);
    opa("rst_recover", 8'h02, 2'b01, 8'hFE, 1'b0, 1'b0, 0);

    opb("w16_neg1234", 16'h1234, 2'b01, 16'hEDCC, 1'b0, 1'b0);
    opb("w16_abs8000", 16'h8000, 2'b10, 16'h8000, 1'b1, 1'b0);
    opb("w16_absfffe", 16'hFFFE, 2'b10, 16'h0002, 1'b0, 1'b0);

    acc0 = acc_a;
    em0 = em_a;
    to = 0;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          a.in_valid = 1'b1;
          a.in_data = 8'($urandom);
          a.mode = 2'($urandom);
          w = 0;
          while (!a.in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
          end
          if (w >= 100) to++;
          @(posedge clk); #1;
          a.in_valid = 1'b0;
        end
        w = 0;
        while (em_a - em0 < 1000 && w < 500) begin
          @(posedge clk); #1;
          w++;
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          a.out_ready = 1'($urandom_range(0, 1));
        end
        a.out_ready = 1'b0;
      end
    join
    chk("rnd_timeouts", 64'(to), 64'd0);
    chk("rnd_accepts", 64'(acc_a - acc0), 64'd1000);
    chk("rnd_balance", 64'(em_a - em0), 64'(acc_a - acc0));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
